// File: rtl/seg_scan_pkg.sv
// Shared constants and types for the 7-segment scan receiver:
// segment patterns, digit-enable codes and the frame assembly states.
package seg_scan_pkg;

  localparam logic [6:0] SEG_0 = 7'b1111110;
  localparam logic [6:0] SEG_1 = 7'b0110000;
  localparam logic [6:0] SEG_2 = 7'b1101101;
  localparam logic [6:0] SEG_3 = 7'b1111001;
  localparam logic [6:0] SEG_4 = 7'b0110011;
  localparam logic [6:0] SEG_5 = 7'b1011011;
  localparam logic [6:0] SEG_6 = 7'b1011111;
  localparam logic [6:0] SEG_7 = 7'b1110000;
  localparam logic [6:0] SEG_8 = 7'b1111111;
  localparam logic [6:0] SEG_9 = 7'b1110011;

  localparam logic [3:0] CATH_H   = 4'b1011;
  localparam logic [3:0] CATH_T   = 4'b1101;
  localparam logic [3:0] CATH_O   = 4'b1110;
  localparam logic [3:0] CATH_OFF = 4'b1111;

  typedef enum logic [1:0] {
    WAIT_H = 2'd0,
    WAIT_T = 2'd1,
    WAIT_O = 2'd2,
    DONE   = 2'd3
  } scan_state_t;

  function automatic logic is_digit_cath(input logic [3:0] cath);
    return (cath == CATH_H) || (cath == CATH_T) || (cath == CATH_O);
  endfunction

endpackage

// File: rtl/seg_scan_decoder_seg7.sv
// seg7_to_bcd: maps an active-high {A..G} segment pattern back to its decimal digit.
// Anything that is not one of the ten digit glyphs (including blank) is invalid.
module seg7_to_bcd
  import seg_scan_pkg::*;
(
  input  logic [6:0] seg,
  output logic       valid,
  output logic [3:0] bcd
);

  // Glyph lookup
  always_comb begin
    valid = 1'b1;
    bcd   = 4'd0;
    case (seg)
      SEG_0:   bcd = 4'd0;
      SEG_1:   bcd = 4'd1;
      SEG_2:   bcd = 4'd2;
      SEG_3:   bcd = 4'd3;
      SEG_4:   bcd = 4'd4;
      SEG_5:   bcd = 4'd5;
      SEG_6:   bcd = 4'd6;
      SEG_7:   bcd = 4'd7;
      SEG_8:   bcd = 4'd8;
      SEG_9:   bcd = 4'd9;
      default: begin
        valid = 1'b0;
        bcd   = 4'd0;
      end
    endcase
  end

endmodule

// File: rtl/seg_scan_decoder.sv
// Receive side of the multiplexed 3-digit display: synchronizes the pins, waits for each
// digit to dwell long enough, reassembles hundreds/tens/ones and recovers the 8-bit value.
module seg_scan_decoder
  import seg_scan_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int SYNC_STAGES   = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] seg_in,
  input  logic [3:0] cathode_in,
  output logic [7:0] value_out,
  output logic       value_valid,
  output logic       frame_err
);

  localparam int CW = $clog2(STABLE_CYCLES + 3);
  localparam logic [CW-1:0] STABLE_W = CW'(STABLE_CYCLES);

  logic [3:0]    cath_sync_r [SYNC_STAGES];
  logic [6:0]    seg_sync_r  [SYNC_STAGES];
  logic [3:0]    cath_s;
  logic [6:0]    seg_s;
  logic [10:0]   prev_r;
  logic          same_s;
  logic [CW-1:0] cnt_r;
  logic [CW-1:0] run_s;
  logic          capture_s;
  logic          seg_valid_s;
  logic [3:0]    seg_bcd_s;
  logic [9:0]    sum_s;

  scan_state_t state_r, state_nxt;
  logic [3:0]  h_r, h_nxt;
  logic [3:0]  t_r, t_nxt;
  logic [7:0]  value_nxt;
  logic        valid_nxt;
  logic        err_nxt;

  // Pin synchronizers; reset value looks like "no digit, blank"
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        cath_sync_r[i] <= CATH_OFF;
        seg_sync_r[i]  <= 7'd0;
      end
    end else begin
      cath_sync_r[0] <= cathode_in;
      seg_sync_r[0]  <= seg_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        cath_sync_r[i] <= cath_sync_r[i-1];
        seg_sync_r[i]  <= seg_sync_r[i-1];
      end
    end
  end

  assign cath_s = cath_sync_r[SYNC_STAGES-1];
  assign seg_s  = seg_sync_r[SYNC_STAGES-1];
  assign same_s = ({cath_s, seg_s} == prev_r);

  // Previous sample and saturating stability count
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_r <= {CATH_OFF, 7'd0};
      cnt_r  <= '0;
    end else begin
      prev_r <= {cath_s, seg_s};
      if (!same_s) begin
        cnt_r <= '0;
      end else if (cnt_r < STABLE_W) begin
        cnt_r <= cnt_r + CW'(1);
      end else begin
        cnt_r <= cnt_r;
      end
    end
  end

  // run_s is the length of the current run of identical samples, this one included
  always_comb begin
    if (same_s) begin
      run_s = cnt_r + CW'(2);
    end else begin
      run_s = CW'(1);
    end
  end

  assign capture_s = is_digit_cath(cath_s) && (run_s == STABLE_W);

  seg7_to_bcd u_seg7 (
    .seg   (seg_s),
    .valid (seg_valid_s),
    .bcd   (seg_bcd_s)
  );

  // h*100 + t*10 + o with the ones digit taken straight from the live capture
  always_comb begin
    sum_s = (10'(h_r) << 6) + (10'(h_r) << 5) + (10'(h_r) << 2)
          + (10'(t_r) << 3) + (10'(t_r) << 1) + 10'(seg_bcd_s);
  end

  // Frame assembly next-state and next-output logic
  always_comb begin
    state_nxt = state_r;
    h_nxt     = h_r;
    t_nxt     = t_r;
    value_nxt = value_out;
    valid_nxt = 1'b0;
    err_nxt   = 1'b0;
    case (state_r)
      WAIT_H: begin
        if (capture_s && (cath_s == CATH_H)) begin
          if (seg_valid_s) begin
            h_nxt     = seg_bcd_s;
            state_nxt = WAIT_T;
          end else begin
            err_nxt   = 1'b1;
            state_nxt = WAIT_H;
          end
        end else begin
          state_nxt = WAIT_H;
        end
      end
      WAIT_T, WAIT_O: begin
        if (!capture_s) begin
          state_nxt = state_r;
        end else if (!seg_valid_s) begin
          err_nxt   = 1'b1;
          state_nxt = WAIT_H;
        end else if ((state_r == WAIT_T) && (cath_s == CATH_T)) begin
          t_nxt     = seg_bcd_s;
          state_nxt = WAIT_O;
        end else if ((state_r == WAIT_O) && (cath_s == CATH_O)) begin
          state_nxt = DONE;
          if (sum_s <= 10'd255) begin
            value_nxt = sum_s[7:0];
            valid_nxt = 1'b1;
          end else begin
            err_nxt   = 1'b1;
          end
        end else if (cath_s == CATH_H) begin
          err_nxt   = 1'b1;
          h_nxt     = seg_bcd_s;
          state_nxt = WAIT_T;
        end else begin
          err_nxt   = 1'b1;
          state_nxt = WAIT_H;
        end
      end
      DONE: begin
        state_nxt = WAIT_H;
      end
      default: begin
        state_nxt = WAIT_H;
      end
    endcase
  end

  // State, digit holding registers and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= WAIT_H;
      h_r         <= 4'd0;
      t_r         <= 4'd0;
      value_out   <= 8'd0;
      value_valid <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      state_r     <= state_nxt;
      h_r         <= h_nxt;
      t_r         <= t_nxt;
      value_out   <= value_nxt;
      value_valid <= valid_nxt;
      frame_err   <= err_nxt;
    end
  end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Bench for seg_scan_decoder: directed scenarios plus random frames, checked every cycle
// against a digit-stream reference model and against fixed per-scenario expectations.
module tb_seg_scan_decoder;
  import seg_scan_pkg::*;

  localparam int ST   = 4;
  localparam int SY   = 2;
  localparam int MAXC = 8192;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] seg_in;
  logic [3:0] cathode_in;
  logic [7:0] value_out;
  logic       value_valid;
  logic       frame_err;

  always #5 clk = ~clk;

  seg_scan_decoder #(.STABLE_CYCLES(ST), .SYNC_STAGES(SY)) dut (
    .clk         (clk),
    .reset       (reset),
    .seg_in      (seg_in),
    .cathode_in  (cathode_in),
    .value_out   (value_out),
    .value_valid (value_valid),
    .frame_err   (frame_err)
  );

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int run = 0;
  int have = 0;
  int dh = 0;
  int dt = 0;
  int mval = 0;
  int n_valid = 0;
  int n_err = 0;
  logic [10:0] last_p;
  bit ev_v [MAXC];
  bit ev_e [MAXC];
  int ev_val [MAXC];
  logic [6:0] segtab [10];

  function automatic int dec(input logic [6:0] s);
    for (int i = 0; i < 10; i++) if (segtab[i] == s) return i;
    return -1;
  endfunction

  function automatic logic [3:0] cath_of(input int pos);
    case (pos)
      0:       return CATH_H;
      1:       return CATH_T;
      default: return CATH_O;
    endcase
  endfunction

  task automatic post(input int due, input bit v, input bit e, input int val);
    if (due < MAXC) begin
      ev_v[due] = v;
      ev_e[due] = e;
      ev_val[due] = val;
    end
  endtask

  // Frame rules applied to one accepted digit; pos 0=H,1=T,2=O; have = digits collected
  task automatic capture(input int pos, input logic [6:0] s, input int due);
    int d;
    int sum;
    d = dec(s);
    if (have == 0) begin
      if (pos == 0) begin
        if (d < 0) post(due, 1'b0, 1'b1, 0);
        else begin dh = d; have = 1; end
      end
    end else if (d < 0) begin
      post(due, 1'b0, 1'b1, 0);
      have = 0;
    end else if (pos != have) begin
      post(due, 1'b0, 1'b1, 0);
      if (pos == 0) begin dh = d; have = 1; end
      else have = 0;
    end else if (have == 1) begin
      dt = d;
      have = 2;
    end else begin
      sum = dh * 100 + dt * 10 + d;
      if (sum <= 255) post(due, 1'b1, 1'b0, sum);
      else post(due, 1'b0, 1'b1, 0);
      have = 0;
    end
  endtask

  task automatic push(input logic [3:0] c, input logic [6:0] s);
    int pos;
    if ({c, s} == last_p) run++;
    else run = 1;
    last_p = {c, s};
    pos = (c == CATH_H) ? 0 : (c == CATH_T) ? 1 : (c == CATH_O) ? 2 : -1;
    if (run == ST && pos >= 0) capture(pos, s, cyc + SY + 1);
  endtask

  task automatic check();
    if (ev_v[cyc]) mval = ev_val[cyc];
    tests++;
    assert (value_valid === ev_v[cyc]) else begin
      fails++;
      $error("FAIL value_valid cyc=%0d got %b exp %b", cyc, value_valid, ev_v[cyc]);
    end
    tests++;
    assert (frame_err === ev_e[cyc]) else begin
      fails++;
      $error("FAIL frame_err cyc=%0d got %b exp %b", cyc, frame_err, ev_e[cyc]);
    end
    tests++;
    assert (value_out === 8'(mval)) else begin
      fails++;
      $error("FAIL value_out cyc=%0d got %0d exp %0d", cyc, value_out, mval);
    end
    tests++;
    assert (!(value_valid === 1'b1 && frame_err === 1'b1)) else begin
      fails++;
      $error("FAIL exclusive cyc=%0d got valid=%b err=%b exp not both", cyc, value_valid, frame_err);
    end
    if (value_valid === 1'b1) n_valid++;
    if (frame_err === 1'b1) n_err++;
  endtask

  task automatic step(input logic [3:0] c, input logic [6:0] s);
    @(negedge clk);
    cyc++;
    check();
    cathode_in = c;
    seg_in = s;
    push(c, s);
  endtask

  task automatic dig(input int pos, input logic [6:0] s, input int len);
    for (int i = 0; i < len; i++) step(cath_of(pos), s);
  endtask

  task automatic gap(input int len);
    for (int i = 0; i < len; i++) step(CATH_OFF, 7'd0);
  endtask

  task automatic do_reset(input int len);
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      cyc++;
      check();
      reset = 1'b1;
      cathode_in = CATH_OFF;
      seg_in = 7'd0;
      for (int j = cyc + 1; j < MAXC; j++) begin
        ev_v[j] = 1'b0;
        ev_e[j] = 1'b0;
      end
      have = 0;
      mval = 0;
      run = 0;
      last_p = {CATH_OFF, 7'd0};
    end
    @(negedge clk);
    cyc++;
    check();
    reset = 1'b0;
  endtask

  task automatic end_test(input string tag, input int exp_v, input int exp_e, input int exp_val);
    tests++;
    assert (n_valid == exp_v) else begin
      fails++;
      $error("FAIL %s valid_pulses got %0d exp %0d", tag, n_valid, exp_v);
    end
    tests++;
    assert (n_err == exp_e) else begin
      fails++;
      $error("FAIL %s err_pulses got %0d exp %0d", tag, n_err, exp_e);
    end
    tests++;
    assert (value_out === 8'(exp_val)) else begin
      fails++;
      $error("FAIL %s value got %0d exp %0d", tag, value_out, exp_val);
    end
    n_valid = 0;
    n_err = 0;
  endtask

  initial begin
    int pos;
    int d;
    logic [6:0] s;
    reset = 1'b1;
    cathode_in = CATH_OFF;
    seg_in = 7'd0;
    last_p = {CATH_OFF, 7'd0};
    segtab[0] = 7'b1111110; segtab[1] = 7'b0110000; segtab[2] = 7'b1101101;
    segtab[3] = 7'b1111001; segtab[4] = 7'b0110011; segtab[5] = 7'b1011011;
    segtab[6] = 7'b1011111; segtab[7] = 7'b1110000; segtab[8] = 7'b1111111;
    segtab[9] = 7'b1110011;

    do_reset(3);
    gap(4);
    end_test("reset", 0, 0, 0);

    // 1: 255 is the largest representable frame
    dig(0, segtab[2], 8); dig(1, segtab[5], 8); dig(2, segtab[5], 8); gap(10);
    end_test("t1_255", 1, 0, 255);

    // 2: 256 overflows, value holds
    dig(0, segtab[2], 8); dig(1, segtab[5], 8); dig(2, segtab[6], 8); gap(10);
    end_test("t2_256", 0, 1, 255);

    // 3: short hundreds dwell, stray tens/ones ignored
    dig(0, segtab[4], 3); dig(1, segtab[2], 8); dig(2, segtab[0], 8); gap(10);
    end_test("t3_short", 0, 0, 255);

    // 4: skipped tens, then a good frame
    dig(0, segtab[1], 8); dig(2, segtab[3], 8);
    dig(0, segtab[0], 8); dig(1, segtab[1], 8); dig(2, segtab[3], 8); gap(10);
    end_test("t4_skip", 1, 1, 13);

    // 5: blank tens with gaps between digits
    dig(0, segtab[0], 8); gap(4); dig(1, 7'd0, 8); gap(4); dig(2, segtab[7], 8); gap(10);
    end_test("t5_blank", 0, 1, 13);

    // 6: reset mid-frame, then a fresh frame
    dig(0, segtab[9], 8); dig(1, segtab[9], 8);
    do_reset(2);
    end_test("t6_reset", 0, 0, 0);
    dig(0, segtab[0], 8); dig(1, segtab[8], 8); dig(2, segtab[9], 8); gap(10);
    end_test("t6_89", 1, 0, 89);

    // Random frames, mostly in order, with occasional misordering and garbage glyphs
    for (int f = 0; f < 40; f++) begin
      for (int k = 0; k < 3; k++) begin
        pos = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 2)) : k;
        d = (k == 0) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 9));
        s = segtab[d];
        if ($urandom_range(0, 11) == 0) s = 7'($urandom_range(0, 127));
        dig(pos, s, int'($urandom_range(2, 9)));
        gap(int'($urandom_range(0, 2)));
      end
    end
    gap(10);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
